// File: rtl/approxexp_arbiter_if.sv
// Requester and engine handshake bundle for approxexp_arbiter.
// slave = arbiter view, master = requester lanes plus exponent engine.
interface approxexp_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_val;
  logic [NUM_REQ-1:0]    req_rdy;
  logic [64*NUM_REQ-1:0] req_ccs;
  logic [64*NUM_REQ-1:0] req_x;
  logic [NUM_REQ-1:0]    rsp_val;
  logic [NUM_REQ-1:0]    rsp_rdy;
  logic [63:0]           rsp_exp;
  logic                  rsp_err;
  logic                  eng_din_val;
  logic                  eng_din_rdy;
  logic [63:0]           eng_ccs;
  logic [63:0]           eng_x;
  logic                  eng_dout_val;
  logic                  eng_dout_rdy;
  logic [63:0]           eng_exp;

  modport slave (
    input  req_val, req_ccs, req_x, rsp_rdy, eng_din_rdy, eng_dout_val, eng_exp,
    output req_rdy, rsp_val, rsp_exp, rsp_err, eng_din_val, eng_ccs, eng_x, eng_dout_rdy
  );

  modport master (
    output req_val, req_ccs, req_x, rsp_rdy, eng_din_rdy, eng_dout_val, eng_exp,
    input  req_rdy, rsp_val, rsp_exp, rsp_err, eng_din_val, eng_ccs, eng_x, eng_dout_rdy
  );
endinterface

// File: rtl/approxexp_arbiter.sv
// Round-robin sharing of one approxexp_v2 engine among NUM_REQ lanes, one job in flight,
// with a result watchdog. Define APPROXEXP_ARB_PRIO_EN to make lane 0 strict highest priority.
module approxexp_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  approxexp_arbiter_if.slave  bus,
  output logic                busy,
  output logic [ID_W-1:0]     grant_id,
  output logic                timeout_err,
  output logic                spurious_err
);

  localparam int unsigned N     = NUM_REQ;
  localparam int          CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           r_state, w_next;
  logic [ID_W-1:0]  r_rr_ptr, r_grant_id, w_winner, w_rr_next;
  logic             w_any, w_tmo;
  logic [63:0]      r_ccs, r_x, r_rsp_exp, w_sel_ccs, w_sel_x;
  logic             r_rsp_err, r_timeout_err, r_spurious_err;
  logic [CNT_W-1:0] r_wdog;

`ifdef APPROXEXP_ARB_PRIO_EN
  localparam logic [ID_W-1:0] RR_RST = ID_W'(1);

  // Lane 0 preempts; otherwise search lanes 1..N-1 from ptr, wrapping back to 1.
  // Descending offset so the closest hit to ptr is the last one written.
  function automatic logic [ID_W-1:0] f_pick(input logic [NUM_REQ-1:0] val,
                                             input logic [ID_W-1:0]    ptr);
    int unsigned idx;
    f_pick = '0;
    for (int unsigned k = N - 1; k > 0; k--) begin
      idx = 32'(ptr) + k - 1;
      if (idx >= N) idx = idx - (N - 1);
      if (val[ID_W'(idx)]) f_pick = ID_W'(idx);
    end
    if (val[0]) f_pick = '0;
  endfunction

  always_comb begin
    if (r_grant_id == '0)                    w_rr_next = r_rr_ptr;
    else if (r_grant_id == ID_W'(N - 1))     w_rr_next = ID_W'(1);
    else                                     w_rr_next = r_grant_id + ID_W'(1);
  end
`else
  localparam logic [ID_W-1:0] RR_RST = '0;

  function automatic logic [ID_W-1:0] f_pick(input logic [NUM_REQ-1:0] val,
                                             input logic [ID_W-1:0]    ptr);
    int unsigned idx;
    f_pick = '0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = 32'(ptr) + k - 1;
      if (idx >= N) idx = idx - N;
      if (val[ID_W'(idx)]) f_pick = ID_W'(idx);
    end
  endfunction

  always_comb begin
    if (r_grant_id == ID_W'(N - 1)) w_rr_next = '0;
    else                            w_rr_next = r_grant_id + ID_W'(1);
  end
`endif

  assign w_any    = |bus.req_val;
  assign w_winner = f_pick(bus.req_val, r_rr_ptr);
  assign w_tmo    = (r_wdog == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_sel_ccs = '0;
    w_sel_x   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_winner == ID_W'(k)) begin
        w_sel_ccs = bus.req_ccs[64*k +: 64];
        w_sel_x   = bus.req_x[64*k +: 64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    bus.req_rdy      = '0;
    bus.rsp_val      = '0;
    bus.eng_din_val  = 1'b0;
    bus.eng_dout_rdy = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          bus.req_rdy[w_winner] = 1'b1;
          w_next                = ISSUE;
        end
      end
      ISSUE: begin
        bus.eng_din_val = 1'b1;
        if (bus.eng_din_rdy) w_next = WAIT;
      end
      WAIT: begin
        bus.eng_dout_rdy = 1'b1;
        if (bus.eng_dout_val || w_tmo) w_next = RESP;
      end
      RESP: begin
        bus.rsp_val[r_grant_id] = 1'b1;
        if (bus.rsp_rdy[r_grant_id]) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr       <= RR_RST;
      r_grant_id     <= '0;
      r_ccs          <= '0;
      r_x            <= '0;
      r_rsp_exp      <= '0;
      r_rsp_err      <= 1'b0;
      r_wdog         <= '0;
      r_timeout_err  <= 1'b0;
      r_spurious_err <= 1'b0;
    end else begin
      if (bus.eng_dout_val && r_state != WAIT) r_spurious_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ccs      <= w_sel_ccs;
            r_x        <= w_sel_x;
            r_grant_id <= w_winner;
          end
        end
        ISSUE: begin
          if (bus.eng_din_rdy) r_wdog <= '0;
        end
        WAIT: begin
          // A result arriving on the timeout cycle takes precedence over the watchdog.
          if (bus.eng_dout_val) begin
            r_rsp_exp <= bus.eng_exp;
            r_rsp_err <= 1'b0;
          end else if (w_tmo) begin
            r_rsp_exp     <= '0;
            r_rsp_err     <= 1'b1;
            r_timeout_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_rdy[r_grant_id]) r_rr_ptr <= w_rr_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.eng_ccs = r_ccs;
  assign bus.eng_x   = r_x;
  assign bus.rsp_exp = r_rsp_exp;
  assign bus.rsp_err = r_rsp_err;
  assign busy        = (r_state != IDLE);
  assign grant_id    = r_grant_id;
  assign timeout_err  = r_timeout_err;
  assign spurious_err = r_spurious_err;

endmodule

// File: tb/tb_approxexp_arbiter.sv
// Directed bench for approxexp_arbiter: job table plus sequences for fairness,
// watchdog, spurious results and mid-job reset.
module tb_approxexp_arbiter;

  localparam int NR  = 4;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [1:0] grant_id;
  logic       timeout_err;
  logic       spurious_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  longint unsigned cyc  = 0;

  logic [63:0] lane_ccs [NR];
  logic [63:0] lane_x   [NR];

  typedef struct {
    logic [3:0]  mask;
    int          lane;
    int          lat;       // 0: engine never answers
    logic [63:0] res;
    int          din_stall;
    int          rsp_stall;
    logic [63:0] exp_exp;
    logic        exp_err;
  } job_t;

  approxexp_arbiter_if #(.NUM_REQ(NR)) bus ();

  approxexp_arbiter #(
    .NUM_REQ(NR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .spurious_err(spurious_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic do_job(input job_t j);
    logic [3:0]  oh;
    logic [63:0] e_ccs, e_x;
    oh    = 4'b0001 << j.lane;
    e_ccs = lane_ccs[j.lane];
    e_x   = lane_x[j.lane];
    bus.req_val = j.mask;
    #1;
    chk("idle_req_rdy", 64'(bus.req_rdy), 64'(oh));
    chk("idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    bus.req_val = j.mask & ~oh;
    #1;
    chk("issue_din_val", 64'(bus.eng_din_val), 64'd1);
    chk("issue_ccs", bus.eng_ccs, e_ccs);
    chk("issue_x", bus.eng_x, e_x);
    chk("issue_grant_id", 64'(grant_id), 64'(j.lane));
    chk("issue_busy", 64'(busy), 64'd1);
    chk("issue_req_rdy", 64'(bus.req_rdy), 64'd0);
    for (int s = 0; s < j.din_stall; s++) begin
      @(negedge clk);
      chk("stall_din_val", 64'(bus.eng_din_val), 64'd1);
      chk("stall_ccs", bus.eng_ccs, e_ccs);
      chk("stall_x", bus.eng_x, e_x);
      chk("stall_req_rdy", 64'(bus.req_rdy), 64'd0);
    end
    bus.eng_din_rdy = 1'b1;
    @(negedge clk);
    bus.eng_din_rdy = 1'b0;
    #1;
    chk("wait_dout_rdy", 64'(bus.eng_dout_rdy), 64'd1);
    chk("wait_din_val", 64'(bus.eng_din_val), 64'd0);
    if (j.lat > 0) begin
      repeat (j.lat - 1) @(negedge clk);
      bus.eng_dout_val = 1'b1;
      bus.eng_exp      = j.res;
      @(negedge clk);
      bus.eng_dout_val = 1'b0;
      bus.eng_exp      = 64'hBAD0_BAD0_BAD0_BAD0;
    end else begin
      repeat (TMO - 1) @(negedge clk);
      chk("tmo_not_yet", 64'(bus.rsp_val), 64'd0);
      chk("tmo_dout_rdy", 64'(bus.eng_dout_rdy), 64'd1);
      @(negedge clk);
    end
    chk("resp_val", 64'(bus.rsp_val), 64'(oh));
    chk("resp_exp", bus.rsp_exp, j.exp_exp);
    chk("resp_err", 64'(bus.rsp_err), 64'(j.exp_err));
    for (int s = 0; s < j.rsp_stall; s++) begin
      bus.rsp_rdy = ~oh;
      @(negedge clk);
      chk("rstall_val", 64'(bus.rsp_val), 64'(oh));
      chk("rstall_exp", bus.rsp_exp, j.exp_exp);
      chk("rstall_req_rdy", 64'(bus.req_rdy), 64'd0);
    end
    bus.rsp_rdy = 4'hF;
    @(negedge clk);
    bus.rsp_rdy = 4'h0;
    bus.req_val = 4'h0;
    #1;
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_rsp_val", 64'(bus.rsp_val), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    job_t tbl [9];
    job_t j;
    longint unsigned t0;

    lane_ccs = '{64'h3FF0000000000000, 64'h0123456789ABCDEF, 64'h4000000000000000, 64'hFEDCBA9876543210};
    lane_x   = '{64'h1000000000000001, 64'h2222222222222222, 64'h3FE0000000000000, 64'h8000000000000000};

    rst = 1'b1;
    bus.req_val = '0;
    bus.rsp_rdy = '0;
    bus.eng_din_rdy = 1'b0;
    bus.eng_dout_val = 1'b0;
    bus.eng_exp = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_ccs[64*i +: 64] = lane_ccs[i];
      bus.req_x[64*i +: 64]   = lane_x[i];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
    chk("rst_rsp_val", 64'(bus.rsp_val), 64'd0);
    chk("rst_din_val", 64'(bus.eng_din_val), 64'd0);
    chk("rst_dout_rdy", 64'(bus.eng_dout_rdy), 64'd0);
    chk("rst_eng_ccs", bus.eng_ccs, 64'd0);
    chk("rst_rsp_exp", bus.rsp_exp, 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_spurious_err", 64'(spurious_err), 64'd0);

`ifdef APPROXEXP_ARB_PRIO_EN
    tbl[0] = '{4'b1001, 0, 4, 64'h11, 0, 0, 64'h11, 1'b0};
    tbl[1] = '{4'b1001, 0, 4, 64'h22, 0, 0, 64'h22, 1'b0};
    tbl[2] = '{4'b1001, 0, 4, 64'h33, 0, 0, 64'h33, 1'b0};
    tbl[3] = '{4'b1000, 3, 4, 64'h44, 0, 0, 64'h44, 1'b0};
    tbl[4] = '{4'b1110, 1, 2, 64'h55, 0, 0, 64'h55, 1'b0};
    tbl[5] = '{4'b1111, 0, 2, 64'h66, 0, 0, 64'h66, 1'b0};
    tbl[6] = '{4'b1110, 2, 2, 64'h77, 0, 0, 64'h77, 1'b0};
    tbl[7] = '{4'b1010, 3, 2, 64'h88, 3, 2, 64'h88, 1'b0};
    tbl[8] = '{4'b1011, 0, 64, 64'hA5A5A5A5A5A5A5A5, 0, 0, 64'hA5A5A5A5A5A5A5A5, 1'b0};
`else
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      j = '{4'hF, i % 4, 5, 64'h100 + 64'(i), 0, 0, 64'h100 + 64'(i), 1'b0};
      do_job(j);
    end
    chk("fair_period", 64'(cyc - t0), 64'(8 * (5 + 3)));

    tbl[0] = '{4'b0100, 2, 15, 64'h1234, 0, 0, 64'h1234, 1'b0};
    tbl[1] = '{4'b1111, 3, 4, 64'hDEADBEEF00000001, 0, 0, 64'hDEADBEEF00000001, 1'b0};
    tbl[2] = '{4'b1111, 0, 1, 64'hFFFFFFFFFFFFFFFF, 0, 0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[3] = '{4'b0101, 2, 2, 64'h0, 0, 0, 64'h0, 1'b0};
    tbl[4] = '{4'b0011, 0, 3, 64'h7FF0000000000000, 0, 0, 64'h7FF0000000000000, 1'b0};
    tbl[5] = '{4'b1001, 3, 6, 64'h3FF8000000000000, 0, 0, 64'h3FF8000000000000, 1'b0};
    tbl[6] = '{4'b1000, 3, 2, 64'h1, 0, 0, 64'h1, 1'b0};
    tbl[7] = '{4'b0010, 1, 9, 64'hCAFEF00D12345678, 5, 7, 64'hCAFEF00D12345678, 1'b0};
    tbl[8] = '{4'b0100, 2, 64, 64'hA5A5A5A5A5A5A5A5, 0, 0, 64'hA5A5A5A5A5A5A5A5, 1'b0};
`endif
    for (int i = 0; i < 9; i++) do_job(tbl[i]);
    chk("pre_tmo_timeout_err", 64'(timeout_err), 64'd0);

    // Watchdog: engine never answers.
    j = '{4'b0001, 0, 0, 64'h0, 0, 0, 64'h0, 1'b1};
    do_job(j);
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
    j = '{4'b0001, 0, 3, 64'h77, 0, 0, 64'h77, 1'b0};
    do_job(j);
    chk("tmo_still_sticky", 64'(timeout_err), 64'd1);
    chk("pre_spur", 64'(spurious_err), 64'd0);

    // Result with no job in flight.
    bus.eng_dout_val = 1'b1;
    bus.eng_exp = 64'h5A5A;
    @(negedge clk);
    bus.eng_dout_val = 1'b0;
    @(negedge clk);
    chk("spur_flag", 64'(spurious_err), 64'd1);
    chk("spur_rsp_val", 64'(bus.rsp_val), 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);

    // Reset while waiting on the engine.
    bus.req_val = 4'b0010;
    #1;
    chk("rstjob_req_rdy", 64'(bus.req_rdy), 64'b0010);
    @(negedge clk);
    bus.req_val = 4'b0000;
    bus.eng_din_rdy = 1'b1;
    @(negedge clk);
    bus.eng_din_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstjob_in_wait", 64'(bus.eng_dout_rdy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_grant_id", 64'(grant_id), 64'd0);
    chk("mid_rst_dout_rdy", 64'(bus.eng_dout_rdy), 64'd0);
    chk("mid_rst_rsp_val", 64'(bus.rsp_val), 64'd0);
    chk("mid_rst_eng_ccs", bus.eng_ccs, 64'd0);
    chk("mid_rst_rsp_exp", bus.rsp_exp, 64'd0);
    chk("mid_rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("mid_rst_spurious_err", 64'(spurious_err), 64'd0);
    j = '{4'hF, 0, 3, 64'h99, 0, 0, 64'h99, 1'b0};
    do_job(j);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approxexp_arbiter.md
Name: approxexp_arbiter

Overview:
- Shares one approxexp_v2 engine among NUM_REQ requesters, e.g. parallel BerExp / sampler lanes.
- Round-robin arbitration; one job in flight at a time.
- Latches the winner's operands, issues them to the engine, captures the result and returns it to the owning requester with a valid/ready handshake.
- Sits between the sampler lanes and the single exponent datapath; adds a watchdog for lost results.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester index.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before the watchdog fires (must exceed engine latency).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_val  in  NUM_REQ  per-requester job valid
- req_rdy  out  NUM_REQ  per-requester accept, one-hot or zero
- req_ccs  in  64*NUM_REQ  ccs operand; lane i occupies bits [64i+63:64i]
- req_x  in  64*NUM_REQ  x operand, packed the same way
- rsp_val  out  NUM_REQ  per-requester result valid, one-hot or zero
- rsp_rdy  in  NUM_REQ  per-requester result accept
- rsp_exp  out  64  result data, shared by all lanes
- rsp_err  out  1  qualifies rsp_exp as a timed-out, invalid result
- eng_din_val  out  1  engine input valid
- eng_din_rdy  in  1  engine input ready
- eng_ccs  out  64  engine ccs operand
- eng_x  out  64  engine x operand
- eng_dout_val  in  1  engine result valid
- eng_dout_rdy  out  1  engine result ready
- eng_exp  in  64  engine result
- busy  out  1  high whenever state is not IDLE
- grant_id  out  ID_W  owner of the current job
- timeout_err  out  1  sticky, cleared only by rst
- spurious_err  out  1  sticky; eng_dout_val seen outside WAIT

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset: IDLE, rr_ptr=0, grant_id=0, all outputs 0, sticky flags 0.
- IDLE:
  - Winner = first i with req_val[i], searching from rr_ptr upward with wrap.
  - req_rdy[winner]=1 combinationally in the same cycle.
  - Latch req_ccs/req_x of the winner into operand registers; grant_id<=winner; go ISSUE.
  - No req_val: stay in IDLE, all req_rdy=0.
- ISSUE: eng_din_val=1, eng_ccs/eng_x from the operand registers. When eng_din_rdy, go WAIT and clear the watchdog counter. Operands stay stable while stalled.
- WAIT:
  - eng_dout_rdy=1; the watchdog counter increments each cycle.
  - On eng_dout_val: rsp_exp<=eng_exp, rsp_err<=0, go RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 with no eng_dout_val: rsp_exp<=0, rsp_err<=1, timeout_err<=1, go RESP.
  - eng_dout_val in the same cycle as the timeout: the result wins.
- RESP:
  - rsp_val[grant_id]=1; rsp_exp/rsp_err held stable.
  - On rsp_rdy[grant_id]: rr_ptr<=grant_id+1 (wraps modulo NUM_REQ, also for non-power-of-2 NUM_REQ), go IDLE.
  - rsp_rdy on other lanes is ignored.
- eng_dout_val in IDLE/ISSUE/RESP: data is dropped, spurious_err<=1.
- Throughput: IDLE→ISSUE→WAIT back-to-back. Minimum job period = engine latency + 3 cycles (IDLE, ISSUE, RESP), given rsp_rdy is held high.
- A requester may drop req_val before it is granted without side effects. After its req_rdy it must not re-request until its response is taken.
- rst mid-operation returns to IDLE and the in-flight job is discarded. The engine shares rst, so no late result arrives.
- rr_ptr is unchanged by cycles with no grant.

Optional Feature:
- APPROXEXP_ARB_PRIO_EN
  - Defined: lane 0 is strict highest priority; in IDLE, req_val[0] always wins, and lanes 1..NUM_REQ-1 round-robin among themselves only when req_val[0]=0. rr_ptr never points to 0, and a lane-0 grant leaves rr_ptr unchanged.
  - Undefined: pure round-robin over all lanes as described above.

Test Plan:
- Single job: req_val[2]=1, ccs=0x4000000000000000, x=0x3FE0000000000000; engine model returns 0x1234 after 15 cycles → req_rdy[2] pulses once, eng operands match, rsp_val[2] with rsp_exp=0x1234 and rsp_err=0, busy low after rsp_rdy.
- Fairness: all 4 lanes hold req_val for 8 jobs, rsp_rdy=1 → grant order 0,1,2,3,0,1,2,3; job period = engine latency + 3.
- Backpressure: eng_din_rdy low for 5 cycles in ISSUE; rsp_rdy low for 7 cycles in RESP → operands and rsp_exp stable throughout, no extra grants.
- Timeout: engine never returns, TIMEOUT_CYCLES=64 → after 64 WAIT cycles rsp_val[owner]=1 with rsp_exp=0, rsp_err=1, timeout_err stays 1 until rst.
- Spurious/reset: pulse eng_dout_val in IDLE → spurious_err=1, no rsp_val; assert rst during WAIT → next cycle IDLE, all outputs 0, rr_ptr=0.
- PRIO_EN build: lanes 0 and 3 request continuously → lane 0 granted every job; release lane 0 → lane 3 granted next.
